fir_frame_sequencer: RTL

Sequences framed sample streams through one bandpass_fir instance, which has no stall input and unknown fixed latency. Accepts a frame from a ready/valid source and drives the FIR's valid_in/data_in. Appends TAP_CNT-1 zero samples so the full convolution tail emerges. Buffers FIR outputs in a credit-protected FIFO, so downstream backpressure never drops a sample.

---
 rtl/fir_seq_pkg.sv | 22 ++
 rtl/fir_out_fifo.sv | 58 +++++
 rtl/fir_frame_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared types and sizing helpers for the FIR frame sequencer
package fir_seq_pkg;

  // Frame sequencer states: wait for start, feed samples, push zero tail, wait for sink
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Number of zero samples needed to push the full convolution tail out of the FIR
  function automatic int flush_len(input int tap_cnt);
    return tap_cnt - 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - synchronous first-word-fall-through FIFO for FIR output samples
module fir_out_fifo
  import fir_seq_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept a push
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  // Head is presented combinationally; forced to zero when there is nothing valid
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fir_frame_sequencer.sv
// rtl/fir_frame_sequencer.sv - feeds framed samples plus a zero tail through a FIR and buffers its output
module fir_frame_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TAP_CNT    = 31,
  parameter int GAIN_W     = 4,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         frame_len,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     fir_valid_in,
  output logic [DATA_W-1:0]        fir_data_in,
  input  logic                     fir_valid_out,
  input  logic [DATA_W+GAIN_W-1:0] fir_data_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W+GAIN_W-1:0] m_data,
  output logic                     m_last,
  output logic                     err
);

  localparam int FLUSH_LEN = flush_len(TAP_CNT);
  localparam int CNT_W     = cnt_width(FIFO_DEPTH);
  localparam int FL_W      = (TAP_CNT > 2) ? $clog2(TAP_CNT) : 1;
  localparam int OUT_W     = LEN_W + $clog2(TAP_CNT + 1);

  seq_state_t        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_in_cnt;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [OUT_W-1:0]  r_out_cnt;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_fir_valid;
  logic [DATA_W-1:0] r_fir_data;
  logic              r_done;
  logic              r_err;

  logic              w_can_issue;
  logic              w_accept;
  logic              w_flush_issue;
  logic              w_issue;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W-1:0]  w_out_next;
  logic [OUT_W-1:0]  w_last_idx;

  // Credits cover every sample in flight through the FIR plus those waiting in the FIFO
  assign w_can_issue   = (r_outstanding < CNT_W'(FIFO_DEPTH));
  assign s_ready       = (r_state == RUN) && w_can_issue;
  assign w_accept      = s_valid && s_ready;
  assign w_flush_issue = (r_state == FLUSH) && w_can_issue;
  assign w_issue       = w_accept || w_flush_issue;
  assign m_valid       = (w_fifo_count != '0);
  assign w_pop         = m_ready && !w_fifo_empty;
  // FIR output with no frame open, or with no room even after a same-cycle pop, is lost
  assign w_push        = fir_valid_out && (r_state != IDLE) && (!w_fifo_full || w_pop);
  assign w_drop        = fir_valid_out && !w_push;
  assign w_out_next    = r_outstanding + CNT_W'(w_issue) - CNT_W'(w_pop);
  assign w_last_idx    = OUT_W'(r_len) + OUT_W'(TAP_CNT - 2);

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign fir_valid_in  = r_fir_valid;
  assign fir_data_in   = r_fir_data;
  assign m_last        = m_valid && (r_out_cnt == w_last_idx);

  fir_out_fifo #(
    .WIDTH (DATA_W + GAIN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (fir_data_out),
    .pop   (w_pop),
    .rdata (m_data),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // Frame FSM with registered FIR drive, credit counter, done pulse and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_in_cnt      <= '0;
      r_flush_cnt   <= '0;
      r_out_cnt     <= '0;
      r_outstanding <= '0;
      r_fir_valid   <= 1'b0;
      r_fir_data    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_fir_valid   <= w_issue;
      r_fir_data    <= w_accept ? s_data : '0;
      r_outstanding <= w_out_next;
      r_done        <= 1'b0;
      if (w_drop) r_err <= 1'b1;
      if (w_pop && (r_state != IDLE)) r_out_cnt <= r_out_cnt + OUT_W'(1);

      case (r_state)
        IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              r_state     <= RUN;
              r_len       <= frame_len;
              r_in_cnt    <= '0;
              r_flush_cnt <= '0;
              r_out_cnt   <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_in_cnt <= r_in_cnt + LEN_W'(1);
            if (r_in_cnt == r_len - LEN_W'(1)) begin
              r_state <= (FLUSH_LEN == 0) ? DRAIN : FLUSH;
            end
          end
        end
        FLUSH: begin
          if (w_can_issue) begin
            r_flush_cnt <= r_flush_cnt + FL_W'(1);
            if (r_flush_cnt == FL_W'(FLUSH_LEN - 1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the cycle after the last sample leaves through m
          if (w_out_next == '0) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
